// File: rtl/seq_decoder.sv
// Registered index with a one-hot step bus: decode/hold mode or auto-advancing
// sequence mode wrapping at a programmable last step.
module seq_decoder #(
    parameter int WIDTH = 3,
    parameter int LAST  = 2**WIDTH - 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                EN,
    input  logic                MODE,
    input  logic                LOAD,
    input  logic                CLR,
    input  logic [WIDTH-1:0]    S,
    output logic [2**WIDTH-1:0] D,
    output logic [WIDTH-1:0]    IDX,
    output logic                WRAP,
    output logic                ERR
);

    localparam logic [WIDTH-1:0] LAST_V = WIDTH'(LAST);

    logic             en_q;
    logic [WIDTH-1:0] idx_d;
    logic             wrap_d;
    logic             err_d;
    logic             load_bad;

    // Widened compare keeps the range check meaningful when LAST is the top code.
    assign load_bad = ({1'b0, S} > {1'b0, LAST_V});

    always_comb begin
        idx_d  = IDX;
        wrap_d = 1'b0;
        err_d  = 1'b0;
        if (CLR) begin
            idx_d = '0;
        end else if (LOAD) begin
            if (load_bad) begin
                err_d = 1'b1;
            end else begin
                idx_d = S;
            end
        end else if (MODE && EN) begin
            if (IDX == LAST_V) begin
                idx_d  = '0;
                wrap_d = 1'b1;
            end else begin
                idx_d = IDX + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            IDX  <= '0;
            en_q <= 1'b0;
            WRAP <= 1'b0;
            ERR  <= 1'b0;
        end else begin
            IDX  <= idx_d;
            en_q <= EN;
            WRAP <= wrap_d;
            ERR  <= err_d;
        end
    end

    always_comb begin
        D = '0;
        if (en_q) begin
            D[IDX] = 1'b1;
        end
    end

endmodule

// File: tb/tb_seq_decoder.sv
// Bench for seq_decoder: three instances (LAST=4, 7, 0) driven in lockstep,
// checked every cycle against a modular-arithmetic model plus literal pins.
module tb_seq_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, mode, load, clr;
    logic [2:0] s;

    logic [7:0] d_o   [3];
    logic [2:0] idx_o [3];
    logic       wrap_o[3];
    logic       err_o [3];

    int lasts[3] = '{4, 7, 0};

    int m_idx [3];
    int m_en  [3];
    int m_wrap[3];
    int m_err [3];

    int errors = 0;
    int checks = 0;
    bit run_cmp = 1'b0;

    always #5 clk = ~clk;

    seq_decoder #(.WIDTH(3), .LAST(4)) u4 (
        .clk(clk), .rst_n(rst_n), .EN(en), .MODE(mode), .LOAD(load), .CLR(clr), .S(s),
        .D(d_o[0]), .IDX(idx_o[0]), .WRAP(wrap_o[0]), .ERR(err_o[0])
    );
    seq_decoder #(.WIDTH(3), .LAST(7)) u7 (
        .clk(clk), .rst_n(rst_n), .EN(en), .MODE(mode), .LOAD(load), .CLR(clr), .S(s),
        .D(d_o[1]), .IDX(idx_o[1]), .WRAP(wrap_o[1]), .ERR(err_o[1])
    );
    seq_decoder #(.WIDTH(3), .LAST(0)) u0 (
        .clk(clk), .rst_n(rst_n), .EN(en), .MODE(mode), .LOAD(load), .CLR(clr), .S(s),
        .D(d_o[2]), .IDX(idx_o[2]), .WRAP(wrap_o[2]), .ERR(err_o[2])
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: index lives in 0..LAST, so advancing is (idx+1) mod (LAST+1).
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                m_idx[k]  <= 0;
                m_en[k]   <= 0;
                m_wrap[k] <= 0;
                m_err[k]  <= 0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                m_en[k]   <= int'(en);
                m_wrap[k] <= (!clr && !load && mode && en && m_idx[k] == lasts[k]) ? 1 : 0;
                m_err[k]  <= (!clr && load && int'(s) > lasts[k]) ? 1 : 0;
                if (clr)
                    m_idx[k] <= 0;
                else if (load) begin
                    if (int'(s) <= lasts[k]) m_idx[k] <= int'(s);
                end else if (mode && en)
                    m_idx[k] <= (m_idx[k] + 1) % (lasts[k] + 1);
            end
        end
    end

    always @(negedge clk) begin
        if (run_cmp) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("idx[%0d]", k),  int'(idx_o[k]),  m_idx[k]);
                chk($sformatf("d[%0d]", k),    int'(d_o[k]),    m_en[k] != 0 ? (1 << m_idx[k]) : 0);
                chk($sformatf("wrap[%0d]", k), int'(wrap_o[k]), m_wrap[k]);
                chk($sformatf("err[%0d]", k),  int'(err_o[k]),  m_err[k]);
            end
        end
    end

    task automatic drive(input logic e, input logic m, input logic l, input logic c, input logic [2:0] sv);
        en = e; mode = m; load = l; clr = c; s = sv;
        @(posedge clk);
        #1;
    endtask

    int wraps;

    initial begin
        rst_n = 1'b0;
        en = 0; mode = 0; load = 0; clr = 0; s = '0;
        #12;
        chk("reset_idx", int'(idx_o[0]), 0);
        chk("reset_d", int'(d_o[0]), 0);
        chk("reset_wrap", int'(wrap_o[0]), 0);
        chk("reset_err", int'(err_o[0]), 0);
        rst_n = 1'b1;
        run_cmp = 1'b1;

        // Decode and hold
        drive(1, 0, 1, 0, 3'd2);
        chk("dec_idx", int'(idx_o[0]), 2);
        chk("dec_d", int'(d_o[0]), 8'h04);
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 0, 0, 3'd0);
            chk("dec_hold", int'(d_o[0]), 8'h04);
        end

        // Sequence walk with wrap
        drive(1, 1, 0, 1, 3'd0);
        chk("seq_start", int'(d_o[0]), 8'h01);
        begin
            int exp_d[5] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h01};
            int exp_w[5] = '{0, 0, 0, 0, 1};
            for (int i = 0; i < 5; i++) begin
                drive(1, 1, 0, 0, 3'd0);
                chk("seq_d", int'(d_o[0]), exp_d[i]);
                chk("seq_wrap", int'(wrap_o[0]), exp_w[i]);
                chk("last0_wrap", int'(wrap_o[2]), 1);
            end
        end
        drive(1, 0, 0, 0, 3'd0);
        chk("wrap_clears", int'(wrap_o[0]), 0);

        // Out-of-range load
        drive(1, 0, 1, 0, 3'd1);
        drive(1, 0, 1, 0, 3'd6);
        chk("bad_err", int'(err_o[0]), 1);
        chk("bad_idx", int'(idx_o[0]), 1);
        chk("bad_d", int'(d_o[0]), 8'h02);
        chk("ok_load_l7", int'(idx_o[1]), 6);
        drive(1, 0, 0, 0, 3'd0);
        chk("err_clears", int'(err_o[0]), 0);

        // CLR beats LOAD and advance; then EN=0 freezes
        drive(1, 0, 1, 0, 3'd4);
        drive(1, 1, 1, 1, 3'd3);
        chk("pri_idx", int'(idx_o[0]), 0);
        chk("pri_wrap", int'(wrap_o[0]), 0);
        chk("pri_err", int'(err_o[0]), 0);
        drive(0, 1, 0, 0, 3'd0);
        chk("dis_d", int'(d_o[0]), 0);
        drive(0, 1, 0, 0, 3'd0);
        chk("dis_idx", int'(idx_o[0]), 0);

        // Full range on LAST=7: 9 advances from 0
        drive(1, 1, 0, 1, 3'd0);
        wraps = 0;
        for (int i = 0; i < 9; i++) begin
            drive(1, 1, 0, 0, 3'd0);
            wraps += int'(wrap_o[1]);
            if (i == 7) chk("full_wrap_idx", int'(idx_o[1]), 0);
        end
        chk("full_wraps", wraps, 1);
        chk("full_end_idx", int'(idx_o[1]), 1);

        // Asynchronous reset mid-sequence at IDX=3
        drive(1, 1, 0, 1, 3'd0);
        for (int i = 0; i < 3; i++) drive(1, 1, 0, 0, 3'd0);
        chk("pre_rst_idx", int'(idx_o[0]), 3);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_idx", int'(idx_o[0]), 0);
        chk("arst_d", int'(d_o[0]), 0);
        chk("arst_wrap", int'(wrap_o[0]), 0);
        #1 rst_n = 1'b1;
        drive(1, 1, 0, 0, 3'd0);
        chk("post_rst_idx", int'(idx_o[0]), 1);
        chk("post_rst_d", int'(d_o[0]), 8'h02);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
                  3'($urandom_range(0, 7)));
            if ($urandom_range(0, 49) == 0) begin
                rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end

        @(negedge clk);
        #1;
        run_cmp = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
